// File: rtl/sr_simd_pkg.sv
// Shared types and helpers for the packed-SIMD saturating shift unit.
package sr_simd_pkg;

  typedef enum logic [1:0] {
    SIMD_KSLL    = 2'b00,
    SIMD_KSLRA   = 2'b01,
    SIMD_KSLRA_U = 2'b10
  } simd_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift-amount width: enough for a signed range of -ELEN..ELEN-1.
  function automatic int saw_f(input int elen);
    return $clog2(elen) + 1;
  endfunction

endpackage

// File: rtl/sr_simd_lane.sv
// One-lane combinational saturating shifter: left shifts saturate, right shifts
// are arithmetic with optional round-half-up.
module sr_simd_lane
  import sr_simd_pkg::*;
#(
  parameter int ELEN = 8,
  parameter int SAW  = saw_f(ELEN)
) (
  input  logic signed [ELEN-1:0] x,
  input  logic        [SAW-1:0]  s,
  input  logic        [1:0]      op,
  output logic        [ELEN-1:0] y,
  output logic                   ov
);

  localparam int W2 = 2 * ELEN;
  localparam logic [ELEN:0] ONE = 1;

  // Returns {ov, lane}; the value fits when the top ELEN+1 bits are all sign copies.
  function automatic logic [ELEN:0] sat_left(input logic signed [W2-1:0] v);
    logic [ELEN:0] r;
    if (v[W2-1:ELEN-1] == {(ELEN+1){v[W2-1]}})
      r = {1'b0, v[ELEN-1:0]};
    else if (v[W2-1])
      r = {1'b1, 1'b1, {(ELEN-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(ELEN-1){1'b1}}};
    return r;
  endfunction

  // Adding half an LSB before the shift gives round-half-up; ELEN+1 bits never overflow.
  function automatic logic [ELEN-1:0] round_shr(input logic signed [ELEN-1:0] v,
                                                input logic [SAW-2:0] m);
    logic signed [ELEN:0] sum;
    logic        [ELEN:0] inc;
    inc = ONE << (m - 1'b1);
    sum = $signed({v[ELEN-1], v}) + $signed(inc);
    sum = sum >>> m;
    return sum[ELEN-1:0];
  endfunction

  logic signed [W2-1:0] xw;
  logic signed [W2-1:0] lv;
  logic signed [W2-1:0] rv;
  logic        [SAW-1:0] neg_s;
  logic        [SAW-2:0] m;
  logic        [ELEN:0]  sat;
  logic                  left;

  always_comb begin
    xw    = {{ELEN{x[ELEN-1]}}, x};
    neg_s = -s;
    m     = neg_s[SAW-1] ? '1 : neg_s[SAW-2:0];
    left  = (op == SIMD_KSLL) | ~s[SAW-1];
    lv    = xw <<< s[SAW-2:0];
    rv    = xw >>> m;
    sat   = sat_left(lv);
    y     = x;
    ov    = 1'b0;
    if (left) begin
      y  = sat[ELEN-1:0];
      ov = sat[ELEN];
    end else if (op == SIMD_KSLRA_U) begin
      y = round_shr(x, m);
    end else begin
      y = rv[ELEN-1:0];
    end
  end

endmodule

// File: rtl/sr_simd_shift_unit.sv
// Multi-cycle packed-SIMD saturating shift unit with valid/ready handshakes,
// processing LANES_PER_CYCLE lanes per BUSY cycle and tracking a sticky overflow.
module sr_simd_shift_unit
  import sr_simd_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ELEN            = 8,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_ov,
  output logic            ov_sticky,
  input  logic            ov_clear
);

  localparam int NLANES = XLEN / ELEN;
  localparam int SAW    = saw_f(ELEN);
  localparam int CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NLANES - LANES_PER_CYCLE);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(LANES_PER_CYCLE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              ov_q, ov_d;
  logic              sticky_q, sticky_d;
  logic [XLEN-1:0]   a_q;
  logic [SAW-1:0]    b_q;
  logic [1:0]        op_q;
  logic              accept;
  logic              load;

  logic [ELEN-1:0]            lane_x [LANES_PER_CYCLE];
  logic [ELEN-1:0]            lane_y [LANES_PER_CYCLE];
  logic [LANES_PER_CYCLE-1:0] lane_ov;

  logic unused_b;
  assign unused_b = ^in_b[XLEN-1:SAW];

  for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
    sr_simd_lane #(
      .ELEN (ELEN),
      .SAW  (SAW)
    ) u_lane (
      .x  (lane_x[j]),
      .s  (b_q),
      .op (op_q),
      .y  (lane_y[j]),
      .ov (lane_ov[j])
    );
  end

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_ov     = ov_q;
  assign ov_sticky  = sticky_q;

  always_comb begin
    for (int j = 0; j < LANES_PER_CYCLE; j++)
      lane_x[j] = a_q[ELEN*(int'(cnt_q)+j) +: ELEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ov_d     = ov_q;
    sticky_d = sticky_q & ~ov_clear;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          ov_d    = 1'b0;
          load    = 1'b1;
        end
      end
      BUSY: begin
        for (int j = 0; j < LANES_PER_CYCLE; j++)
          res_d[ELEN*(int'(cnt_q)+j) +: ELEN] = lane_y[j];
        ov_d = ov_q | (|lane_ov);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          // A set on the DONE entry edge overrides a simultaneous clear.
          if (ov_d) sticky_d = 1'b1;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_d = BUSY;
            ov_d    = 1'b0;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ov_q     <= ov_d;
      sticky_q <= sticky_d;
    end
  end

  // Operand capture needs no reset: it is only consumed after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= in_a;
      b_q  <= in_b[SAW-1:0];
      op_q <= in_op;
    end
  end

endmodule

// File: tb/tb_sr_simd_shift_unit.sv
// Directed bench for the SIMD shift unit: vector table plus hand-written
// backpressure, sticky-flag, reset-abort and wide-lane sequences.
module tb_sr_simd_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_ready, ov_clear;

  logic        in_valid8, in_ready8, out_valid8, out_ov8, ov_sticky8;
  logic [31:0] out_result8;
  logic        in_valid16, in_ready16, out_valid16, out_ov16, ov_sticky16;
  logic [31:0] out_result16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_simd_shift_unit #(.XLEN(32), .ELEN(8), .LANES_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid8),
    .out_ready(out_ready), .out_result(out_result8), .out_ov(out_ov8),
    .ov_sticky(ov_sticky8), .ov_clear(ov_clear)
  );

  sr_simd_shift_unit #(.XLEN(32), .ELEN(16), .LANES_PER_CYCLE(2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid16),
    .out_ready(out_ready), .out_result(out_result16), .out_ov(out_ov16),
    .ov_sticky(ov_sticky16), .ov_clear(ov_clear)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int sel, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_op = op;
    in_a  = a;
    in_b  = b;
    if (sel == 1) in_valid16 = 1'b1;
    else          in_valid8  = 1'b1;
    step();
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (((sel == 1) ? out_valid16 : out_valid8) !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    vecs[0] = '{2'b00, 32'h0140C07F, 32'h00000001, 32'h027F807F, 1'b1};
    vecs[1] = '{2'b00, 32'h80FF0011, 32'h00000000, 32'h80FF0011, 1'b0};
    vecs[2] = '{2'b01, 32'h807FF010, 32'hABCDEF0D, 32'hF00FFE02, 1'b0};
    vecs[3] = '{2'b10, 32'h807FF010, 32'h0000000D, 32'hF010FE02, 1'b0};
    vecs[4] = '{2'b01, 32'h807FF010, 32'h00000008, 32'hFF00FF00, 1'b0};
    vecs[5] = '{2'b11, 32'h807FF010, 32'h0000000D, 32'hF00FFE02, 1'b0};
    vecs[6] = '{2'b01, 32'h20DF0110, 32'h00000002, 32'h7F800440, 1'b1};
    vecs[7] = '{2'b00, 32'h00FF0100, 32'h0000000F, 32'h00807F00, 1'b1};
    vecs[8] = '{2'b10, 32'h037F81FF, 32'h0000000F, 32'h0240C100, 1'b0};

    rst = 1'b1; in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready = 1'b1;
    ov_clear = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset out_valid", 32'(out_valid8), 32'd0);
    chk("reset in_ready", 32'(in_ready8), 32'd1);
    chk("reset out_result", out_result8, 32'h0);
    chk("reset out_ov", 32'(out_ov8), 32'd0);
    chk("reset ov_sticky", 32'(ov_sticky8), 32'd0);

    for (int i = 0; i < 9; i++) begin
      start(0, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d result", i), out_result8, vecs[i].res);
      chk($sformatf("vec%0d ov", i), 32'(out_ov8), 32'(vecs[i].ov));
      if (i == 0) chk("vec0 sticky", 32'(ov_sticky8), 32'd1);
      step();
    end

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    start(0, vecs[2].op, vecs[2].a, vecs[2].b);
    wait_done(0, lat);
    chk("bp latency", 32'(lat), 32'd4);
    in_valid8 = 1'b1; in_op = 2'b00; in_a = 32'h7F7F7F7F; in_b = 32'h1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d valid", k), 32'(out_valid8), 32'd1);
      chk($sformatf("bp hold%0d result", k), out_result8, 32'hF00FFE02);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready8), 32'd0);
      step();
    end
    in_op = vecs[4].op; in_a = vecs[4].a; in_b = vecs[4].b;
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready8), 32'd1);
    step();
    in_valid8 = 1'b0;
    chk("b2b busy valid", 32'(out_valid8), 32'd0);
    wait_done(0, lat);
    chk("b2b latency", 32'(lat), 32'd4);
    chk("b2b result", out_result8, 32'hFF00FF00);
    step();

    // Sticky flag: set beats a simultaneous clear, clear alone drops it.
    ov_clear = 1'b1;
    start(0, vecs[0].op, vecs[0].a, vecs[0].b);
    chk("sticky cleared in busy", 32'(ov_sticky8), 32'd0);
    wait_done(0, lat);
    chk("sticky set wins", 32'(ov_sticky8), 32'd1);
    ov_clear = 1'b0;
    step();
    chk("sticky holds", 32'(ov_sticky8), 32'd1);
    ov_clear = 1'b1;
    step();
    ov_clear = 1'b0;
    chk("sticky clear", 32'(ov_sticky8), 32'd0);

    // Reset mid-BUSY aborts the operation.
    start(0, vecs[0].op, vecs[0].a, vecs[0].b);
    wait_done(0, lat);
    step();
    chk("pre-abort sticky", 32'(ov_sticky8), 32'd1);
    start(0, vecs[0].op, vecs[0].a, vecs[0].b);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid8), 32'd0);
    chk("abort sticky", 32'(ov_sticky8), 32'd0);
    chk("abort in_ready", 32'(in_ready8), 32'd1);
    chk("abort result", out_result8, 32'h0);
    repeat (6) step();
    chk("abort no late valid", 32'(out_valid8), 32'd0);

    // Wide lanes, two lanes per cycle.
    start(1, 2'b00, 32'h4000FFFF, 32'h00000001);
    wait_done(1, lat);
    chk("e16 latency", 32'(lat), 32'd1);
    chk("e16 result", out_result16, 32'h7FFFFFFE);
    chk("e16 ov", 32'(out_ov16), 32'd1);
    chk("e16 sticky", 32'(ov_sticky16), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
